// File: rtl/lfsr_stream_checker.sv
// rtl/lfsr_stream_checker.sv - receiver-side checker for LFSR generator word streams
// Seeds a local predictor from the stream, tracks lock, and counts good/bad words.
module lfsr_stream_checker #(
  parameter int W        = 32,
  parameter int TAP      = 8,
  parameter int STEP     = 33,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             din_valid,
  input  logic [W-1:0]     din,
  output logic             busy,
  output logic             locked,
  output logic             err_pulse,
  output logic             overrun,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SW-1:0]    STEP_LAST = SW'(STEP - 1);
  localparam logic [SW-1:0]    STEP_ONE  = SW'(1);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    MATCH_PRE = MW'(LOCK_CNT - 1);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);
  localparam logic [LW-1:0]    MISS_PRE  = LW'(LOSS_CNT - 1);
  localparam logic [LW-1:0]    MISS_ONE  = LW'(1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_ADVANCE,
    S_WAIT
  } state_t;

  state_t         state;
  logic [W-1:0]   pred;
  logic [SW-1:0]  step_cnt;
  logic [MW-1:0]  match_cnt;
  logic [LW-1:0]  miss_cnt;

  function automatic logic [W-1:0] shift_once(input logic [W-1:0] s);
    return {s[W-2:0], s[W-1] ^ s[TAP]};
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_HUNT;
      pred       <= '0;
      step_cnt   <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      overrun    <= 1'b0;
      good_count <= '0;
      err_count  <= '0;
    end else begin
      err_pulse <= 1'b0;
      overrun   <= 1'b0;
      if (clear) begin
        state      <= S_HUNT;
        pred       <= '0;
        step_cnt   <= '0;
        match_cnt  <= '0;
        miss_cnt   <= '0;
        busy       <= 1'b0;
        locked     <= 1'b0;
        good_count <= '0;
        err_count  <= '0;
      end else begin
        case (state)
          S_HUNT: begin
            // An all-zero word is a dead LFSR state and can never seed.
            if (din_valid && din != '0) begin
              pred      <= din;
              step_cnt  <= '0;
              match_cnt <= '0;
              state     <= S_ADVANCE;
              busy      <= 1'b1;
            end
          end
          S_ADVANCE: begin
            pred <= shift_once(pred);
            if (din_valid) overrun <= 1'b1;
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              state    <= S_WAIT;
              busy     <= 1'b0;
            end else begin
              step_cnt <= step_cnt + STEP_ONE;
            end
          end
          S_WAIT: begin
            if (din_valid) begin
              step_cnt <= '0;
              if (din == pred) begin
                if (good_count != '1) good_count <= good_count + CNT_ONE;
                miss_cnt <= '0;
                if (match_cnt < MATCH_MAX) match_cnt <= match_cnt + MATCH_ONE;
                if (match_cnt >= MATCH_PRE) locked <= 1'b1;
                state <= S_ADVANCE;
                busy  <= 1'b1;
              end else if (!locked) begin
                match_cnt <= '0;
                if (din != '0) begin
                  pred  <= din;
                  state <= S_ADVANCE;
                  busy  <= 1'b1;
                end else begin
                  state <= S_HUNT;
                end
              end else begin
                // Keep the predicted value so one corrupted word cannot desync us.
                err_pulse <= 1'b1;
                if (err_count != '1) err_count <= err_count + CNT_ONE;
                if (miss_cnt == MISS_PRE) begin
                  locked    <= 1'b0;
                  match_cnt <= '0;
                  miss_cnt  <= '0;
                  state     <= S_HUNT;
                end else begin
                  miss_cnt <= miss_cnt + MISS_ONE;
                  state    <= S_ADVANCE;
                  busy     <= 1'b1;
                end
              end
            end
          end
          default: begin
            state <= S_HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb/tb_lfsr_stream_checker.sv - self-checking bench for lfsr_stream_checker
// Instance 0: W=16 STEP=1 narrow counters; instance 1: defaults.
module tb_lfsr_stream_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        clear0 = 1'b0, dv0 = 1'b0;
  logic [15:0] din0 = '0;
  logic        busy0, locked0, errp0, ovr0;
  logic [3:0]  good0, err0;

  logic        clear1 = 1'b0, dv1 = 1'b0;
  logic [31:0] din1 = '0;
  logic        busy1, locked1, errp1, ovr1;
  logic [15:0] good1, err1;

  lfsr_stream_checker #(
    .W(16), .TAP(8), .STEP(1), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(4)
  ) u_small (
    .clk(clk), .rstn(rstn), .clear(clear0), .din_valid(dv0), .din(din0),
    .busy(busy0), .locked(locked0), .err_pulse(errp0), .overrun(ovr0),
    .good_count(good0), .err_count(err0)
  );

  lfsr_stream_checker dut (
    .clk(clk), .rstn(rstn), .clear(clear1), .din_valid(dv1), .din(din1),
    .busy(busy1), .locked(locked1), .err_pulse(errp1), .overrun(ovr1),
    .good_count(good1), .err_count(err1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference model, one slot per instance.
  logic [31:0] m_pred[2];
  bit          m_hunt[2], m_locked[2], m_errp[2];
  int          m_match[2], m_miss[2], m_good[2], m_err[2];

  function automatic int wid(input int id);  return (id == 0) ? 16 : 32; endfunction
  function automatic int stp(input int id);  return (id == 0) ? 1 : 33; endfunction
  function automatic int cmax(input int id); return (id == 0) ? 15 : 65535; endfunction

  function automatic logic [31:0] adv(input int id, input logic [31:0] s, input int n);
    logic [31:0] v = s;
    logic [31:0] mask = (wid(id) == 32) ? 32'hffff_ffff : 32'h0000_ffff;
    for (int k = 0; k < n; k++) v = ((v << 1) | 32'(v[wid(id)-1] ^ v[8])) & mask;
    return v;
  endfunction

  task automatic model_reset(input int id);
    m_pred[id] = '0; m_hunt[id] = 1; m_locked[id] = 0; m_errp[id] = 0;
    m_match[id] = 0; m_miss[id] = 0; m_good[id] = 0; m_err[id] = 0;
  endtask

  task automatic model_word(input int id, input logic [31:0] w);
    m_errp[id] = 0;
    if (m_hunt[id]) begin
      if (w != 0) begin
        m_hunt[id] = 0; m_match[id] = 0; m_pred[id] = adv(id, w, stp(id));
      end
    end else if (w == m_pred[id]) begin
      if (m_good[id] < cmax(id)) m_good[id]++;
      m_miss[id] = 0;
      if (m_match[id] < LOCK) m_match[id]++;
      if (m_match[id] == LOCK) m_locked[id] = 1;
      m_pred[id] = adv(id, m_pred[id], stp(id));
    end else if (!m_locked[id]) begin
      m_match[id] = 0;
      if (w != 0) m_pred[id] = adv(id, w, stp(id));
      else m_hunt[id] = 1;
    end else begin
      m_errp[id] = 1;
      if (m_err[id] < cmax(id)) m_err[id]++;
      m_miss[id]++;
      if (m_miss[id] == LOSS) begin
        m_locked[id] = 0; m_match[id] = 0; m_miss[id] = 0; m_hunt[id] = 1;
      end else begin
        m_pred[id] = adv(id, m_pred[id], stp(id));
      end
    end
  endtask

  task automatic drive(input int id, input logic v, input logic [31:0] w);
    if (id == 0) begin dv0 = v; din0 = w[15:0]; end
    else begin dv1 = v; din1 = w; end
  endtask

  task automatic sample(input int id, output logic [31:0] b, output logic [31:0] l,
                        output logic [31:0] e, output logic [31:0] o,
                        output logic [31:0] g, output logic [31:0] c);
    if (id == 0) begin
      b = 32'(busy0); l = 32'(locked0); e = 32'(errp0); o = 32'(ovr0); g = 32'(good0); c = 32'(err0);
    end else begin
      b = 32'(busy1); l = 32'(locked1); e = 32'(errp1); o = 32'(ovr1); g = 32'(good1); c = 32'(err1);
    end
  endtask

  // Sends one word, checks the registered result, then waits out the busy window,
  // optionally poking din_valid at busy cycle ovr to provoke an overrun.
  task automatic send(input int id, input logic [31:0] word_in, input int ovr);
    logic [31:0] word, b, l, e, o, g, c;
    word = (id == 0) ? (word_in & 32'h0000_ffff) : word_in;
    @(negedge clk); drive(id, 1'b1, word);
    @(negedge clk); drive(id, 1'b0, '0);
    model_word(id, word);
    sample(id, b, l, e, o, g, c);
    check("busy", b, 32'(!m_hunt[id]));
    check("locked", l, 32'(m_locked[id]));
    check("err_pulse", e, 32'(m_errp[id]));
    check("good_count", g, 32'(m_good[id]));
    check("err_count", c, 32'(m_err[id]));
    for (int i = 1; i <= stp(id); i++) begin
      if (i == ovr && !m_hunt[id]) drive(id, 1'b1, $urandom);
      @(negedge clk);
      if (i == ovr && !m_hunt[id]) begin
        drive(id, 1'b0, '0);
        sample(id, b, l, e, o, g, c);
        check("overrun", o, 1);
        check("ovr_good", g, 32'(m_good[id]));
        check("ovr_err", c, 32'(m_err[id]));
      end
      if (i == 1) begin
        sample(id, b, l, e, o, g, c);
        check("err_pulse_width", e, 0);
      end
    end
    sample(id, b, l, e, o, g, c);
    check("busy_done", b, 0);
  endtask

  logic [31:0] g;
  logic [31:0] dir0[12] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80,
                            32'h100, 32'h201, 32'h200, 32'h804};

  initial begin
    model_reset(0); model_reset(1);
    repeat (3) @(negedge clk);
    check("rst_locked0", 32'(locked0), 0);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_good1", 32'(good1), 0);
    check("rst_err1", 32'(err1), 0);
    check("rst_flags1", {28'd0, busy1, locked1, errp1, ovr1}, 0);
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) send(0, dir0[i], 0);
    check("lock_after_5", 32'(locked0), 1);
    check("good_after_5", 32'(good0), 4);
    for (int i = 5; i < 12; i++) send(0, dir0[i], 0);
    check("single_bad_err", 32'(err0), 1);
    check("still_locked", 32'(locked0), 1);
    check("good_after_resync", 32'(good0), 10);

    send(0, 32'h1234, 0);
    send(0, 32'h5555, 0);
    send(0, 32'h0000, 0);
    check("loss_unlocked", 32'(locked0), 0);
    check("loss_err", 32'(err0), 4);
    g = 32'h0003;
    for (int i = 0; i < 5; i++) begin send(0, g, 0); g = adv(0, g, 1); end
    check("relock", 32'(locked0), 1);
    for (int i = 0; i < 12; i++) begin send(0, g, 0); g = adv(0, g, 1); end
    check("good_saturated", 32'(good0), 15);

    @(negedge clk); clear0 = 1'b1; dv0 = 1'b1; din0 = 16'h0001;
    @(negedge clk); clear0 = 1'b0; dv0 = 1'b0;
    model_reset(0);
    check("clear_good", 32'(good0), 0);
    check("clear_err", 32'(err0), 0);
    check("clear_locked", 32'(locked0), 0);
    check("clear_beats_valid", 32'(busy0), 0);
    send(0, 32'h0000, 0);
    send(0, 32'h0001, 0);

    g = $urandom | 32'h1;
    send(1, g, 0); g = adv(1, g, 33);
    send(1, g, 5); g = adv(1, g, 33);
    for (int i = 0; i < 3; i++) begin send(1, g, 0); g = adv(1, g, 33); end
    check("lock_after_overrun", 32'(locked1), 1);

    @(negedge clk); clear1 = 1'b1;
    @(negedge clk); clear1 = 1'b0;
    model_reset(1);
    g = $urandom | 32'h1;
    for (int i = 0; i < 1000; i++) begin send(1, g, 0); g = adv(1, g, 33); end
    check("gold_locked", 32'(locked1), 1);
    check("gold_good", 32'(good1), 999);
    check("gold_err", 32'(err1), 0);

    for (int i = 0; i < 300; i++) begin
      int roll;
      logic [31:0] w;
      roll = int'($urandom_range(0, 9));
      w = g;
      if (roll == 0) w = g ^ (32'h1 << $urandom_range(0, 31));
      send(1, w, (roll == 1) ? int'($urandom_range(1, 33)) : 0);
      g = adv(1, g, 33);
    end

    @(negedge clk); drive(1, 1'b1, g);
    @(negedge clk); drive(1, 1'b0, '0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy1), 0);
    check("async_rst_locked", 32'(locked1), 0);
    check("async_rst_good", 32'(good1), 0);
    @(negedge clk); rstn = 1'b1;
    model_reset(0); model_reset(1);
    send(1, g, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
